// File: rtl/ssdma_m2m_mover_if.sv
// SS DMA mover FIFO-side bus: show-ahead source FIFO and destination FIFO.
// The mover side is master; the FIFO pair is slave.
interface ssdma_m2m_mover_if #(
  parameter int DW = 64
);
  logic          m_src_getn;
  logic [DW-1:0] m_src;
  logic          m_src_last;
  logic          m_src_empty;
  logic          m_dst_putn;
  logic [DW-1:0] m_dst;
  logic          m_dst_last;
  logic          m_dst_full;

  modport master (
    output m_src_getn,
    input  m_src,
    input  m_src_last,
    input  m_src_empty,
    output m_dst_putn,
    output m_dst,
    output m_dst_last,
    input  m_dst_full
  );

  modport slave (
    input  m_src_getn,
    output m_src,
    output m_src_last,
    output m_src_empty,
    input  m_dst_putn,
    input  m_dst,
    input  m_dst_last,
    output m_dst_full
  );
endinterface

// File: rtl/ssdma_m2m_mover.sv
// SS DMA FIFO-to-FIFO word mover with copy/invert/fill modes,
// early-last detection and XOR checksum of written words.
module ssdma_m2m_mover #(
  parameter int DW    = 64,
  parameter int CNT_W = 24
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [CNT_W-1:0] dc,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    pattern,
  input  logic             m_reset1,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DW-1:0]    csum,
  ssdma_m2m_mover_if.master m
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] rem_q;
  logic [1:0]       mode_q;
  logic [DW-1:0]    pat_q;
  logic [DW-1:0]    s_data;
  logic             s_last;
  logic             s_vld;
  logic             err_q;
  logic [DW-1:0]    csum_q;

  logic fill;
  logic inv;
  logic wr;
  logic ld;
  logic early;
  logic rem_nz;
  logic rem_one;

  assign fill    = (mode_q == 2'd2);
  assign inv     = (mode_q == 2'd1);
  assign rem_nz  = (rem_q != '0);
  assign rem_one = (rem_q == CNT_W'(1));
  assign wr      = s_vld & ~m.m_dst_full;
  assign ld      = (state_q == RUN) & rem_nz
                 & (~s_vld | wr)
                 & (fill | ~m.m_src_empty);
  assign early   = ~fill & m.m_src_last;

  assign m.m_src_getn = ~(ld & ~fill);
  assign m.m_dst_putn = ~wr;
  assign m.m_dst      = s_data;
  assign m.m_dst_last = s_last;

  assign busy = (state_q == RUN) | (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign err  = err_q;
  assign csum = csum_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (dc == '0) ? DONE : RUN;
      RUN:   if (!rem_nz) state_d = DRAIN;
      DRAIN: if (!s_vld || wr) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (m_reset1) state_d = IDLE;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      mode_q  <= '0;
      pat_q   <= '0;
      s_data  <= '0;
      s_last  <= 1'b0;
      s_vld   <= 1'b0;
      err_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        rem_q  <= dc;
        mode_q <= mode;
        pat_q  <= pattern;
        err_q  <= 1'b0;
        csum_q <= '0;
      end
      if (wr) csum_q <= csum_q ^ s_data;
      if (ld) begin
        s_data <= fill ? pat_q : (inv ? ~m.m_src : m.m_src);
        s_last <= rem_one | early;
        s_vld  <= 1'b1;
        // source ran out before the count: stop loading, flag it
        if (early && !rem_one) begin
          err_q <= 1'b1;
          rem_q <= '0;
        end else begin
          rem_q <= rem_q - CNT_W'(1);
        end
      end else if (wr) begin
        s_vld <= 1'b0;
      end
      if (m_reset1) begin
        s_vld <= 1'b0;
        rem_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ssdma_m2m_mover.sv
// Directed bench for ssdma_m2m_mover: reset, copy/invert/fill,
// early last, dst back-pressure, null transfer and abort.
module tb_ssdma_m2m_mover;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] dc;
  logic [1:0]  mode;
  logic [63:0] pattern;
  logic        m_reset1;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] csum;
  logic        dst_full;

  logic [63:0] src_mem [0:15];
  int          src_idx;
  int          src_len;
  int          src_lastix;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd[$];
  logic        wl[$];
  int          wc[$];
  int          done_cyc;
  int          done_n;
  int          getn_n;
  int          getn_hold;
  int          unstable;
  logic [63:0] hold;
  logic        busy5;

  ssdma_m2m_mover_if #(.DW(64)) bus ();

  assign bus.m_src       = src_mem[src_idx & 15];
  assign bus.m_src_empty = (src_idx >= src_len);
  assign bus.m_src_last  = (src_idx == src_lastix);
  assign bus.m_dst_full  = dst_full;

  ssdma_m2m_mover #(.DW(64), .CNT_W(24)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .dc       (dc),
    .mode     (mode),
    .pattern  (pattern),
    .m_reset1 (m_reset1),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .csum     (csum),
    .m        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic load_src(input logic [63:0] base, input int len,
                          input int lastix);
    for (int i = 0; i < 16; i++) src_mem[i] = base + 64'(i);
    src_idx    = 0;
    src_len    = len;
    src_lastix = lastix;
  endtask

  // entered and left at posedge+1; cycle 0 carries start
  task automatic xfer(input int n, input logic [1:0] md,
                      input logic [63:0] pat, input int fl_lo,
                      input int fl_hi, input int rst_at,
                      input int ncyc);
    logic popped;
    wd.delete(); wl.delete(); wc.delete();
    done_cyc = -1; done_n = 0; getn_n = 0;
    getn_hold = 0; unstable = 0; hold = '0; busy5 = 1'b1;
    dc = 24'(n); mode = md; pattern = pat;
    for (int k = 0; k < ncyc; k++) begin
      start    = (k == 0);
      dst_full = (k >= fl_lo) && (k <= fl_hi);
      m_reset1 = (k == rst_at);
      @(negedge clk);
      popped = !bus.m_src_getn;
      if (popped) getn_n++;
      if (!bus.m_dst_putn) begin
        wd.push_back(bus.m_dst);
        wl.push_back(bus.m_dst_last);
        wc.push_back(k);
      end
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == 5) busy5 = busy;
      if (dst_full && k >= 3 && k <= 6) begin
        if (popped) getn_hold++;
        if (k == 3) hold = bus.m_dst;
        else if (bus.m_dst !== hold) unstable++;
      end
      @(posedge clk);
      #1;
      if (popped) src_idx++;
    end
    start = 1'b0; m_reset1 = 1'b0; dst_full = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dc = '0; mode = '0;
    pattern = '0; m_reset1 = 1'b0; dst_full = 1'b0;
    load_src(64'h10, 0, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_csum", csum, 64'd0);
    chk("rst_dst", bus.m_dst, 64'd0);
    chk("rst_dlast", 64'(bus.m_dst_last), 64'd0);
    chk("rst_getn", 64'(bus.m_src_getn), 64'd1);
    chk("rst_putn", 64'(bus.m_dst_putn), 64'd1);
    @(posedge clk); #1;

    // copy 4
    load_src(64'h10, 4, -1);
    xfer(4, 2'd0, 64'h0, 99, 99, -1, 12);
    chk("cp_n", 64'(wd.size()), 64'd4);
    if (wd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("cp_data", wd[i], 64'h10 + 64'(i));
        chk("cp_cyc", 64'(wc[i]), 64'(i + 2));
        chk("cp_last", 64'(wl[i]), 64'(i == 3));
      end
    end
    chk("cp_done_cyc", 64'(done_cyc), 64'd7);
    chk("cp_done_n", 64'(done_n), 64'd1);
    chk("cp_csum", csum, 64'h0);
    chk("cp_err", 64'(err), 64'd0);

    // invert 3
    load_src(64'h0F, 8, -1);
    xfer(3, 2'd1, 64'h0, 99, 99, -1, 12);
    chk("inv_n", 64'(wd.size()), 64'd3);
    if (wd.size() == 3) begin
      chk("inv_d0", wd[0], 64'hFFFF_FFFF_FFFF_FFF0);
      chk("inv_d1", wd[1], 64'hFFFF_FFFF_FFFF_FFEF);
      chk("inv_d2", wd[2], 64'hFFFF_FFFF_FFFF_FFEE);
      chk("inv_last", 64'(wl[2]), 64'd1);
    end
    chk("inv_csum", csum, 64'hFFFF_FFFF_FFFF_FFF1);

    // fill 5, source empty
    load_src(64'h0, 0, -1);
    xfer(5, 2'd2, 64'hA5A5, 99, 99, -1, 14);
    chk("fill_n", 64'(wd.size()), 64'd5);
    if (wd.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("fill_data", wd[i], 64'hA5A5);
        chk("fill_last", 64'(wl[i]), 64'(i == 4));
      end
    end
    chk("fill_getn", 64'(getn_n), 64'd0);
    chk("fill_csum", csum, 64'hA5A5);

    // early last on 3rd word
    load_src(64'h30, 8, 2);
    xfer(8, 2'd0, 64'h0, 99, 99, -1, 14);
    chk("el_n", 64'(wd.size()), 64'd3);
    if (wd.size() == 3) begin
      chk("el_d2", wd[2], 64'h32);
      chk("el_last2", 64'(wl[2]), 64'd1);
      chk("el_last1", 64'(wl[1]), 64'd0);
    end
    chk("el_err", 64'(err), 64'd1);
    chk("el_done_n", 64'(done_n), 64'd1);
    chk("el_csum", csum, 64'h33);

    // dst full cycles 3-6
    load_src(64'h20, 8, -1);
    xfer(6, 2'd0, 64'h0, 3, 6, -1, 16);
    chk("bp_err_clr", 64'(err), 64'd0);
    chk("bp_n", 64'(wd.size()), 64'd6);
    if (wd.size() == 6) begin
      for (int i = 0; i < 6; i++)
        chk("bp_data", wd[i], 64'h20 + 64'(i));
      chk("bp_cyc0", 64'(wc[0]), 64'd2);
      chk("bp_cyc1", 64'(wc[1]), 64'd7);
      chk("bp_cyc5", 64'(wc[5]), 64'd11);
      chk("bp_last", 64'(wl[5]), 64'd1);
    end
    chk("bp_hold", hold, 64'h21);
    chk("bp_stable", 64'(unstable), 64'd0);
    chk("bp_getn", 64'(getn_hold), 64'd0);
    chk("bp_csum", csum, 64'h1);

    // null transfer
    load_src(64'h50, 8, -1);
    xfer(0, 2'd0, 64'h0, 99, 99, -1, 6);
    chk("nul_done_cyc", 64'(done_cyc), 64'd1);
    chk("nul_n", 64'(wd.size()), 64'd0);
    chk("nul_getn", 64'(getn_n), 64'd0);

    // abort after 2 writes
    load_src(64'h40, 8, -1);
    xfer(6, 2'd0, 64'h0, 4, 30, 4, 16);
    chk("ab_n", 64'(wd.size()), 64'd2);
    chk("ab_busy", 64'(busy5), 64'd0);
    chk("ab_done", 64'(done_n), 64'd0);
    chk("ab_csum", csum, 64'h1);
    chk("ab_pops", 64'(src_idx), 64'd3);

    // restart dc=1, mode 3 behaves as copy
    xfer(1, 2'd3, 64'h0, 99, 99, -1, 8);
    chk("rs_n", 64'(wd.size()), 64'd1);
    if (wd.size() == 1) begin
      chk("rs_data", wd[0], 64'h43);
      chk("rs_last", 64'(wl[0]), 64'd1);
    end
    chk("rs_done_cyc", 64'(done_cyc), 64'd4);
    chk("rs_csum", csum, 64'h43);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
